// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: diff = a - b - b_in, one nibble per clock through a single
// 4-bit carry-lookahead slice, with a start/busy/done handshake.
module nibble_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    // Handshake: start is sampled only on an edge where busy=0 (IDLE or DONE);
    // done pulses for one cycle when diff/b_out/ovf have just been updated.
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             a_msb;
    logic             b_msb;
    logic             carry_reg;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] res;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       c;
    logic [3:0]       sum;
    logic [WIDTH-1:0] res_next;

    // CLA slice: subtraction as a + ~b + carry, carry=1 meaning "no borrow".
    always_comb begin
        nib_a = a_sh[3:0];
        nib_b = ~b_sh[3:0];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry_reg;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum   = p ^ c[3:0];
        // New nibble enters at the top; after NIB steps the LSB nibble sits at bit 0.
        res_next = WIDTH'({sum, res} >> 4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            res       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            b_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        a_msb     <= a[WIDTH-1];
                        b_msb     <= b[WIDTH-1];
                        carry_reg <= ~b_in;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res       <= res_next;
                    a_sh      <= a_sh >> 4;
                    b_sh      <= b_sh >> 4;
                    carry_reg <= c[4];
                    idx       <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        diff  <= res_next;
                        b_out <= ~c[4];
                        ovf   <= (a_msb != b_msb) && (sum[3] != a_msb);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor (WIDTH=8): directed vector table, handshake
// corner sequences, back-to-back scoreboard and a reference-model sweep.
module tb_nibble_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       b_out;
    logic       ovf;

    int n_vec = 0;
    int n_bad = 0;

    logic [9:0] exp_q[$];

    nibble_serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       b_in;
        logic [7:0] exp_diff;
        logic       exp_b_out;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model packed as {diff, b_out, ovf}
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] r;
        r = {1'b0, x} - {1'b0, y} - {8'd0, bi};
        return {r[7:0], r[8], (x[7] != y[7]) && (r[7] != x[7])};
    endfunction

    // Driver: issue one operation from an idle/done state, scramble operands
    // after acceptance, and wait (bounded) for done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          output logic [9:0] got, output int lat, output logic acc_busy);
        a = ta; b = tb; b_in = tbin; start = 1'b1;
        @(posedge clk); #1;
        acc_busy = busy;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 20);
        got = {diff, b_out, ovf};
    endtask

    initial begin
        logic [9:0] got;
        int         lat;
        logic       acc_busy;
        logic [7:0] ops_a[5];
        logic [7:0] ops_b[5];
        logic       ops_c[5];
        int         n_acc;
        int         n_done;
        int         cyc;
        int         last_cyc;
        logic       prev_busy;
        int         stray;

        vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2]  = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5]  = '{8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[9]  = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[10] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[11] = '{8'h34, 8'h12, 1'b1, 8'h21, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out", {diff, b_out, ovf}, 0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].b_in, got, lat, acc_busy);
            check($sformatf("vec%0d_busy", i), acc_busy, 1);
            check($sformatf("vec%0d_lat", i), lat, 2);
            check($sformatf("vec%0d_diff", i), got[9:2], vecs[i].exp_diff);
            check($sformatf("vec%0d_bout", i), got[1], vecs[i].exp_b_out);
            check($sformatf("vec%0d_ovf", i), got[0], vecs[i].exp_ovf);
        end
        @(posedge clk); #1;
        check("idle_after_done", {busy, done}, 0);

        // start pulsed while busy must be ignored
        a = 8'h42; b = 8'h11; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("pulse_acc_busy", busy, 1);
        @(posedge clk); #1;
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        check("pulse_done", done, 1);
        check("pulse_diff", diff, 8'h31);
        repeat (2) begin
            @(posedge clk); #1;
            check("pulse_no_extra", {busy, done}, 0);
        end
        check("pulse_hold", {diff, b_out, ovf}, {8'h31, 1'b0, 1'b0});

        // Reset one cycle after an accepted start aborts the operation
        a = 8'h99; b = 8'h11; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_acc_busy", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out", {done, diff, b_out, ovf}, 0);
        stray = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) stray++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        check("abort_no_done", stray, 0);
        run_op(8'h99, 8'h11, 1'b0, got, lat, acc_busy);
        check("post_abort_lat", lat, 2);
        check("post_abort_res", got, {8'h88, 1'b0, 1'b0});

        // Back-to-back with start held high, scoreboard of expected results
        ops_a = '{8'h12, 8'hF0, 8'h80, 8'h00, 8'hC3};
        ops_b = '{8'h34, 8'h0F, 8'h7F, 8'h00, 8'h3C};
        ops_c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        @(posedge clk); #1;
        n_acc = 0; n_done = 0; cyc = 0; last_cyc = 0; prev_busy = busy;
        a = ops_a[0]; b = ops_b[0]; b_in = ops_c[0]; start = 1'b1;
        for (int t = 0; t < 40 && n_done < 5; t++) begin
            @(posedge clk); #1;
            cyc++;
            if (busy && !prev_busy) begin
                exp_q.push_back(model(ops_a[n_acc], ops_b[n_acc], ops_c[n_acc]));
                n_acc++;
                if (n_acc < 5) begin
                    a = ops_a[n_acc]; b = ops_b[n_acc]; b_in = ops_c[n_acc];
                end else begin
                    start = 1'b0;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL b2b_unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    check($sformatf("b2b%0d_res", n_done), {diff, b_out, ovf}, exp_q.pop_front());
                end
                if (n_done > 0) check($sformatf("b2b%0d_spacing", n_done), cyc - last_cyc, 3);
                last_cyc = cyc;
                n_done++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("b2b_accepts", n_acc, 5);
        check("b2b_dones", n_done, 5);
        @(posedge clk); #1;

        // Reference sweep, all-zero/all-one corners first
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            logic       bi;
            if (i < 8) begin
                x  = i[0] ? 8'hFF : 8'h00;
                y  = i[1] ? 8'hFF : 8'h00;
                bi = i[2];
            end else begin
                x  = 8'($urandom_range(0, 255));
                y  = 8'($urandom_range(0, 255));
                bi = 1'($urandom_range(0, 1));
            end
            run_op(x, y, bi, got, lat, acc_busy);
            check($sformatf("rnd%0d_lat", i), lat, 2);
            check($sformatf("rnd%0d_res_%0h_%0h_%0d", i, x, y, bi), got, model(x, y, bi));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle subtractor computing diff = a - b - b_in.
- Processes one 4-bit nibble per clock, LSB nibble first, through a single 4-bit carry-lookahead slice fed with a and inverted b, with a registered borrow between nibbles.
- Companion to the team's combinational CLA-based adders: trades latency for one slice of logic.
- Uses a start/busy/done handshake so a datapath controller can issue back-to-back operations.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- b_in  input  1  borrow-in; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- diff  output  WIDTH  result (a - b - b_in) mod 2^WIDTH
- b_out  output  1  borrow out; 1 when a < b + b_in (unsigned)
- ovf  output  1  signed (two's complement) overflow of the subtraction

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, b_out=0, ovf=0; operand registers, nibble index and borrow register cleared.
- Release of reset is synchronous to clk; first start can be sampled on the first rising edge after release.
- States:
  - IDLE: busy=0. start=1 at edge -> latch a, b, b_in; carry_reg=~b_in (carry 1 = no borrow); idx=0; go to RUN.
  - RUN: busy=1. Each edge computes nibble idx as a[idx] + ~b[idx] + carry_reg through the 4-bit CLA slice. The 4-bit sum is written into an internal result shift register, carry_reg takes the slice carry-out, and idx increments.
    - On the edge processing idx=NIB-1: diff takes the full internal result, b_out=~carry_out, ovf=(a_msb!=b_msb)&&(diff_msb!=a_msb), done=1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE, so done and the new busy overlap by 0 cycles. Otherwise go to IDLE, done=0.
- Latency: start sampled at edge k -> done high in the cycle after edge k+NIB (WIDTH=8: 2 edges). Throughput: one operation per NIB+1 cycles when start is held high.
- diff, b_out and ovf are updated only at completion and hold their values until the next completion or reset. They never show partial nibbles.
- start while busy=1 is ignored. a, b and b_in may change freely after acceptance without affecting the result.
- Arithmetic: all nibble arithmetic is modulo 16 with an explicit carry. The final result is modulo 2^WIDTH. b_in=1 with a=b yields diff=all-ones, b_out=1.
- Reset asserted mid-operation aborts immediately: no done pulse, outputs return to reset values.

Test Plan:
- Reset, then a=8'h5A, b=8'h3C, b_in=0, start one cycle -> busy for 2 cycles, done pulse 2 edges after accept; diff=8'h1E, b_out=0, ovf=0.
- a=8'h00, b=8'h01, b_in=0 -> diff=8'hFF, b_out=1, ovf=0. a=8'h10, b=8'h0F, b_in=1 -> diff=8'h00, b_out=0 (borrow propagates across nibble boundary).
- a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, b_out=0. a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1, b_out=1.
- start held high continuously with new operands each accept -> done every 3rd cycle; each diff matches its own operands; start pulses during busy produce no extra done; operand changes after accept do not alter the result.
- Assert rst_n=0 one cycle after an accepted start -> busy=0, done never pulses, diff=0, b_out=0, ovf=0. A subsequent operation computes correctly.
- Randomised sweep of 1000 operand/b_in triples checked against a reference model (a-b-b_in), including all-zero and all-one corners.
